l_class_oc_echo_queue: RTL and testbench
========================================

# l_class_oc_echo_queue

Upstream feeder for the `l_class_OC_foo` indication consumer. It accepts `say(meth, v)` requests and holds them in a DEPTH-entry FIFO. It replays each request in order as an `indication$heard(meth, v)` call under the standard `__RDY`/`__ENA` method handshake. Output firing is exposed as one scheduler rule, `respond`, on `rule_enable`/`rule_ready`, so the top-level scheduler arbitrates it like any other generated rule.

## Interface
- `DEPTH`, default 4: FIFO entries. Power of two, ≥2.
- `CNTW`, default 3: occupancy counter width, equal to clog2(DEPTH+1).

Ports, one clock, reset synchronous and active-low:
- `CLK`  in  1  clock; every register updates on posedge.
- `nRST`  in  1  synchronous active-low reset, sampled on posedge CLK.
- `request$say__ENA`  in  1  enqueue strobe.
- `request$say$meth`  in  32  method id.
- `request$say$v`  in  32  payload.
- `request$say__RDY`  out  1  FIFO not full.
- `indication$heard__ENA`  out  1  downstream call fires this cycle.
- `indication$heard$meth`  out  32  head-entry meth.
- `indication$heard$v`  out  32  head-entry v.
- `indication$heard__RDY`  in  1  downstream can accept.
- `rule_enable`  in  1  bit 0 is the scheduler grant for rule `respond`.
- `rule_ready`  out  1  bit 0 is `respond` ready.
- `sent_count`  out  32  number of heard calls issued since reset.

## Operation
- Storage:
  - DEPTH × 64-bit array holding {meth, v}.
  - `wr_ptr`, `rd_ptr`: log2(DEPTH) bits each, wrap modulo DEPTH.
  - `count`: CNTW bits, range 0..DEPTH.
- `full = (count == DEPTH)`, `empty = (count == 0)`.
- Ready and fire terms:
  - `request$say__RDY = !full`.
  - `enq = request$say__ENA && request$say__RDY`. An ENA presented while not RDY is ignored; no data is lost from the FIFO and the request is not stored.
  - `rule_ready[0] = !empty && indication$heard__RDY`.
  - `deq = rule_enable[0] && rule_ready[0]`.
  - `indication$heard__ENA = deq`.
- `indication$heard$meth` and `indication$heard$v` always present `mem[rd_ptr]`. They are only meaningful while `!empty`.
- On `enq`: write `mem[wr_ptr]`, then increment `wr_ptr`.
- On `deq`: increment `rd_ptr` and `sent_count`.
- `count` update:
  - +1 on enq only.
  - −1 on deq only.
  - Unchanged when both occur.
- There is no bypass. An entry written while empty becomes visible at the head the following cycle.
- `sent_count` wraps from 0xFFFFFFFF to 0 with no flag.

## Timing
- Reset (nRST low at a posedge):
  - `wr_ptr`, `rd_ptr`, `count` and `sent_count` clear to 0.
  - Any ENA or rule grant in that cycle is ignored.
  - Outputs after the reset edge: `request$say__RDY = 1`, `rule_ready = 0`, `indication$heard__ENA = 0`, `sent_count = 0`. Memory contents are don't-care.
- Reset mid-operation discards all queued entries. No heard call fires in the reset cycle.
- Latency, say to heard: minimum 1 cycle. Enq at edge N gives `rule_ready = 1` during cycle N+1, and heard can fire at edge N+1.
- Throughput: 1 enq plus 1 deq per cycle sustained when neither full nor empty.
- Full with simultaneous deq: RDY is already 0, so no enq that cycle. RDY rises the cycle after the deq.
- Empty: enq only. `rule_ready` stays 0 during the enq cycle.
- `indication$heard__RDY` low: the head is held, and meth/v stay stable until deq.
- All outputs are combinational from registers except `rule_ready` and `indication$heard__ENA`. Those two also depend on `indication$heard__RDY` (and ENA on `rule_enable`), with no other input paths.

## Test plan
- Single-request case:
  - Stimulus: reset, then say(meth=5, v=0x1234) with `rule_enable = 1` and `heard__RDY = 1`.
  - Required: heard__ENA pulses exactly one cycle later with meth=5, v=0x1234. `sent_count = 1`, then `rule_ready = 0`.
- Fill to full:
  - Stimulus: `heard__RDY = 0`; enqueue v = 1, 2, 3, 4, then attempt v = 5.
  - Required: `say__RDY = 0` after the 4th. v=5 is dropped. Raising `heard__RDY` yields v = 1, 2, 3, 4 in order, then empty.
- Concurrent enq/deq at steady state:
  - Stimulus: count=2 with back-to-back enq and deq for 10 cycles.
  - Required: count stays 2, output order matches input order, `sent_count` advances by 10.
- Pointer wrap:
  - Stimulus: stream 9 entries through DEPTH=4.
  - Required: values are correct across the wrap.
- Scheduler withholds the grant:
  - Stimulus: queue non-empty, `heard__RDY = 1`, `rule_enable = 0` for 3 cycles.
  - Required: `rule_ready = 1`, heard__ENA = 0, head stable, no deq.
- Reset mid-stream:
  - Stimulus: 3 entries queued, nRST low for one edge.
  - Required: `count = 0`, `say__RDY = 1`, `rule_ready = 0`, `sent_count = 0`. The next say is delivered as the first heard.

Source files
------------

// File: rtl/l_class_oc_echo_queue.sv
// l_class_oc_echo_queue
// ---------------------------------------------------------------------------
// Upstream feeder for the l_class_OC_foo indication consumer. Incoming
// say(meth, v) requests are stored in a DEPTH-entry FIFO. They are replayed in
// order as indication heard(meth, v) calls. A heard call fires through the
// scheduler rule "respond" (rule_ready / rule_enable), so the top-level
// scheduler arbitrates it like any other rule.
//
// Ports
//   CLK                    in   1   clock, all state updates on posedge
//   nRST                   in   1   synchronous active-low reset
//   request_say__ENA       in   1   enqueue strobe (ignored while RDY is low)
//   request_say_meth       in  32   method id to enqueue
//   request_say_v          in  32   payload to enqueue
//   request_say__RDY       out  1   FIFO not full
//   indication_heard__ENA  out  1   heard call fires this cycle
//   indication_heard_meth  out 32   head-entry meth (valid while not empty)
//   indication_heard_v     out 32   head-entry v    (valid while not empty)
//   indication_heard__RDY  in   1   downstream can accept a heard call
//   rule_enable            in   1   scheduler grant for rule "respond"
//   rule_ready             out  1   rule "respond" can fire
//   sent_count             out 32   heard calls issued since reset (wraps)
// ---------------------------------------------------------------------------
module l_class_oc_echo_queue #(
    parameter int DEPTH = 4,
    parameter int CNTW  = 3
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        request_say__ENA,
    input  logic [31:0] request_say_meth,
    input  logic [31:0] request_say_v,
    output logic        request_say__RDY,
    output logic        indication_heard__ENA,
    output logic [31:0] indication_heard_meth,
    output logic [31:0] indication_heard_v,
    input  logic        indication_heard__RDY,
    input  logic        rule_enable,
    output logic        rule_ready,
    output logic [31:0] sent_count
);

    localparam int PTRW = $clog2(DEPTH);

    // Each entry is {meth, v}.
    logic [63:0]     r_mem [DEPTH];
    logic [PTRW-1:0] r_wr_ptr;
    logic [PTRW-1:0] r_rd_ptr;
    logic [CNTW-1:0] r_count;
    logic [31:0]     r_sent_count;

    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_deq;
    logic w_rule_ready;

    assign w_full       = (r_count == CNTW'(DEPTH));
    assign w_empty      = (r_count == '0);
    assign w_enq        = request_say__ENA && !w_full;
    assign w_rule_ready = !w_empty && indication_heard__RDY;
    assign w_deq        = rule_enable && w_rule_ready;

    assign request_say__RDY      = !w_full;
    assign rule_ready            = w_rule_ready;
    assign indication_heard__ENA = w_deq;
    // Head is read straight from storage; a freshly written entry only shows
    // up once count has moved off zero, so there is no write-to-read bypass.
    assign indication_heard_meth = r_mem[r_rd_ptr][63:32];
    assign indication_heard_v    = r_mem[r_rd_ptr][31:0];
    assign sent_count            = r_sent_count;

    // Storage has no reset: contents are meaningless until count says so.
    always_ff @(posedge CLK) begin
        if (nRST && w_enq) begin
            r_mem[r_wr_ptr] <= {request_say_meth, request_say_v};
        end
    end

    // Pointers are exactly log2(DEPTH) bits, so plain increment wraps mod DEPTH.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_sent_count <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_deq) begin
                r_rd_ptr     <= r_rd_ptr + 1'b1;
                r_sent_count <= r_sent_count + 32'd1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: tb/tb_l_class_oc_echo_queue.sv
// Testbench for l_class_oc_echo_queue: directed scenarios followed by random
// traffic, checked against a queue-based reference model of the FIFO.
module tb_l_class_oc_echo_queue;

    localparam int DEPTH = 4;
    localparam int CNTW  = 3;

    logic        clk;
    logic        n_rst;
    logic        say_ena;
    logic [31:0] say_meth;
    logic [31:0] say_v;
    logic        say_rdy;
    logic        heard_ena;
    logic [31:0] heard_meth;
    logic [31:0] heard_v;
    logic        heard_rdy;
    logic        rule_en;
    logic        rule_rdy;
    logic [31:0] sent_cnt;

    l_class_oc_echo_queue #(.DEPTH(DEPTH), .CNTW(CNTW)) dut (
        .CLK                   (clk),
        .nRST                  (n_rst),
        .request_say__ENA      (say_ena),
        .request_say_meth      (say_meth),
        .request_say_v         (say_v),
        .request_say__RDY      (say_rdy),
        .indication_heard__ENA (heard_ena),
        .indication_heard_meth (heard_meth),
        .indication_heard_v    (heard_v),
        .indication_heard__RDY (heard_rdy),
        .rule_enable           (rule_en),
        .rule_ready            (rule_rdy),
        .sent_count            (sent_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: an ordered list of pending {meth, v} and a call tally.
    logic [63:0] model_q[$];
    logic [31:0] model_sent;

    int unsigned vectors;
    int unsigned miscompares;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check outputs
    // against the model, then advance the model across the rising edge.
    task automatic step(input logic ena, input logic [31:0] meth, input logic [31:0] v,
                        input logic ren, input logic hrdy);
        logic exp_rdy;
        logic exp_rr;
        logic exp_fire;
        say_ena   = ena;
        say_meth  = meth;
        say_v     = v;
        rule_en   = ren;
        heard_rdy = hrdy;
        #1;
        exp_rdy  = (model_q.size() < DEPTH);
        exp_rr   = (model_q.size() != 0) && hrdy;
        exp_fire = exp_rr && ren;
        chk("say_rdy",    {31'd0, say_rdy},   {31'd0, exp_rdy});
        chk("rule_ready", {31'd0, rule_rdy},  {31'd0, exp_rr});
        chk("heard_ena",  {31'd0, heard_ena}, {31'd0, exp_fire});
        chk("sent_count", sent_cnt, model_sent);
        if (model_q.size() != 0) begin
            chk("head_meth", heard_meth, model_q[0][63:32]);
            chk("head_v",    heard_v,    model_q[0][31:0]);
        end
        @(posedge clk);
        if (exp_fire) begin
            $display("heard meth=%h v=%h sent=%0d", model_q[0][63:32], model_q[0][31:0], model_sent + 1);
            void'(model_q.pop_front());
            model_sent = model_sent + 32'd1;
        end
        if (ena && exp_rdy) begin
            $display("say   meth=%h v=%h", meth, v);
            model_q.push_back({meth, v});
        end
        @(negedge clk);
    endtask

    // Hold nRST low across one rising edge with traffic presented, which
    // must be ignored.
    task automatic do_reset();
        n_rst     = 1'b0;
        say_ena   = 1'b1;
        say_meth  = 32'hdead;
        say_v     = 32'hbeef;
        rule_en   = 1'b1;
        heard_rdy = 1'b1;
        @(posedge clk);
        model_q.delete();
        model_sent = 32'd0;
        @(negedge clk);
        n_rst = 1'b1;
        $display("reset applied");
    endtask

    logic [31:0] base_sent;

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_sent  = 32'd0;
        n_rst       = 1'b0;
        say_ena     = 1'b0;
        say_meth    = 32'd0;
        say_v       = 32'd0;
        rule_en     = 1'b0;
        heard_rdy   = 1'b0;
        @(negedge clk);
        do_reset();

        // Reset state, then a single request delivered one cycle later.
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 32'd5, 32'h1234, 1'b1, 1'b1);
        chk("single_visible_ready", {31'd0, rule_rdy}, 32'd1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("single_sent", sent_cnt, 32'd1);

        // Fill to full with downstream stalled; the 5th say is dropped.
        for (int i = 1; i <= 5; i++) step(1'b1, 32'd7, i[31:0], 1'b1, 1'b0);
        chk("full_rdy_low", {31'd0, say_rdy}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            chk("drain_order", heard_v, i[31:0]);
            step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        end
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("drain_empty", {31'd0, rule_rdy}, 32'd0);

        // Steady state at two entries with enq and deq every cycle.
        step(1'b1, 32'd1, $urandom, 1'b0, 1'b1);
        step(1'b1, 32'd2, $urandom, 1'b0, 1'b1);
        base_sent = model_sent;
        for (int i = 0; i < 10; i++) step(1'b1, $urandom, $urandom, 1'b1, 1'b1);
        chk("steady_sent", sent_cnt, base_sent + 32'd10);
        chk("steady_count", model_q.size(), 32'd2);
        chk("steady_ready", {31'd0, rule_rdy}, 32'd1);

        // Stream nine more entries so the pointers wrap again, then drain.
        for (int i = 0; i < 9; i++) step(1'b1, 32'd9, 32'h900 + i, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);

        // Grant withheld: ready but no fire, head stays put.
        step(1'b1, 32'h55, 32'haaaa, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
            chk("withhold_head", heard_v, 32'haaaa);
        end

        // Reset with entries queued discards them all.
        step(1'b1, 32'd3, 32'h3, 1'b0, 1'b0);
        step(1'b1, 32'd3, 32'h4, 1'b0, 1'b0);
        do_reset();
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        step(1'b1, 32'h77, 32'h7777, 1'b1, 1'b1);
        chk("post_reset_head", heard_v, 32'h7777);
        step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
        chk("post_reset_sent", sent_cnt, 32'd1);

        // Random traffic.
        for (int i = 0; i < 300; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

endmodule
